// File: rtl/fuzzy_pkg.sv
// -----------------------------------------------------------------------------
// fuzzy_pkg
// Shared constants and types for the fuzzy rule sequencer.
//   MU_W    : width of a membership value / rule weight
//   SUM_W   : width of the weight accumulator (9 full-scale weights fit)
//   N_RULES : rules evaluated per pass (3 temperature sets x 3 delta sets)
//   N_SETS  : fuzzy sets per input (neg, zero, pos)
//   state_t : sequencer states
// -----------------------------------------------------------------------------
package fuzzy_pkg;

  localparam int MU_W    = 16;
  localparam int SUM_W   = MU_W + 4;
  localparam int N_RULES = 9;
  localparam int N_SETS  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/min_u.sv
// -----------------------------------------------------------------------------
// min_u
// Unsigned two-input minimum. On a tie the first operand is returned, which
// is numerically identical to the second.
// Ports:
//   i_a, i_b : operands (MU_W bits, unsigned)
//   o_min    : smaller of the two operands
// -----------------------------------------------------------------------------
module min_u #(
  parameter int MU_W = fuzzy_pkg::MU_W
) (
  input  logic [MU_W-1:0] i_a,
  input  logic [MU_W-1:0] i_b,
  output logic [MU_W-1:0] o_min
);

  // Plain magnitude compare; both operands are unsigned so no sign handling.
  assign o_min = (i_a <= i_b) ? i_a : i_b;

endmodule

// File: rtl/rule_seq.sv
// -----------------------------------------------------------------------------
// rule_seq
// Walks the nine fuzzy rules (temperature set i x delta-T set j) one per
// accepted transfer, emitting each rule weight min(muT[i], muD[j]) over a
// valid/ready handshake and accumulating the sum of emitted weights.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   start               : request a 9-rule pass (only honoured when idle)
//   muT_neg/zero/pos    : temperature memberships, latched at start
//   muD_neg/zero/pos    : delta-T memberships, latched at start
//   busy                : high from start acceptance until the done cycle ends
//   w_valid / w_ready   : weight handshake, transfer when both high
//   w_idx               : rule index 3*i+j
//   w_data              : rule weight for w_idx
//   sum_w               : running / final sum of transferred weights
//   done                : one-cycle pulse when the pass completes
// -----------------------------------------------------------------------------
module rule_seq #(
  parameter int MU_W  = fuzzy_pkg::MU_W,
  parameter int SUM_W = fuzzy_pkg::SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MU_W-1:0]  muT_neg,
  input  logic [MU_W-1:0]  muT_zero,
  input  logic [MU_W-1:0]  muT_pos,
  input  logic [MU_W-1:0]  muD_neg,
  input  logic [MU_W-1:0]  muD_zero,
  input  logic [MU_W-1:0]  muD_pos,
  output logic             busy,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [3:0]       w_idx,
  output logic [MU_W-1:0]  w_data,
  output logic [SUM_W-1:0] sum_w,
  output logic             done
);

  import fuzzy_pkg::*;

  localparam logic [1:0] LAST_SET = 2'(N_SETS - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [1:0]       r_i;
  logic [1:0]       r_j;
  logic [MU_W-1:0]  r_muT [N_SETS];
  logic [MU_W-1:0]  r_muD [N_SETS];
  logic [SUM_W-1:0] r_sum;
  logic [MU_W-1:0]  w_selT;
  logic [MU_W-1:0]  w_selD;
  logic [MU_W-1:0]  w_min;
  logic             w_lastRule;
  logic             w_xfer;
  logic             w_accept;

  // The pass ends on the transfer of the rule where both set counters are
  // at their last value; the counters never wrap inside a pass.
  assign w_lastRule = (r_i == LAST_SET) && (r_j == LAST_SET);
  assign w_accept   = (r_state == IDLE) && start;

  // Next-state logic. Start is only looked at in IDLE, and a transfer is
  // only possible in RUN, so stray starts or ready pulses elsewhere do nothing.
  always_comb begin
    w_nextState = r_state;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_xfer = w_ready;
        if (w_ready && w_lastRule) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register; reset wins over anything sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath: latch the memberships on an accepted start so later input
  // changes cannot disturb the pass, then step j (inner) and i (outer) on
  // every transfer while adding the emitted weight into the sum. The sum
  // is left alone after the pass so it stays readable until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i   <= 2'd0;
      r_j   <= 2'd0;
      r_sum <= '0;
      for (int k = 0; k < N_SETS; k++) begin
        r_muT[k] <= '0;
        r_muD[k] <= '0;
      end
    end else if (w_accept) begin
      r_i      <= 2'd0;
      r_j      <= 2'd0;
      r_sum    <= '0;
      r_muT[0] <= muT_neg;
      r_muT[1] <= muT_zero;
      r_muT[2] <= muT_pos;
      r_muD[0] <= muD_neg;
      r_muD[1] <= muD_zero;
      r_muD[2] <= muD_pos;
    end else if (w_xfer) begin
      r_sum <= r_sum + SUM_W'(w_min);
      if (!w_lastRule) begin
        if (r_j == LAST_SET) begin
          r_j <= 2'd0;
          r_i <= r_i + 2'd1;
        end else begin
          r_j <= r_j + 2'd1;
        end
      end
    end
  end

  // Operand selection for the shared min unit, one latched value per input.
  always_comb begin
    w_selT = '0;
    w_selD = '0;
    case (r_i)
      2'd0:    w_selT = r_muT[0];
      2'd1:    w_selT = r_muT[1];
      2'd2:    w_selT = r_muT[2];
      default: w_selT = '0;
    endcase
    case (r_j)
      2'd0:    w_selD = r_muD[0];
      2'd1:    w_selD = r_muD[1];
      2'd2:    w_selD = r_muD[2];
      default: w_selD = '0;
    endcase
  end

  // A single min unit serves all nine rules, one rule per cycle.
  min_u #(
    .MU_W (MU_W)
  ) u_min (
    .i_a   (w_selT),
    .i_b   (w_selD),
    .o_min (w_min)
  );

  // Outputs. The index is 3*i+j formed as 2*i + i + j.
  assign busy    = (r_state != IDLE);
  assign w_valid = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign w_idx   = {1'b0, r_i, 1'b0} + {2'b00, r_i} + {2'b00, r_j};
  assign w_data  = w_valid ? w_min : '0;
  assign sum_w   = r_sum;

endmodule
